// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin write arbiter feeding a shared register bank
module reg_bank_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  hold,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   output logic [DEPTH-1:0]      wr_en,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_src,
   output logic                  err_addr
);

   // One extra bit so DEPTH itself is representable when 2**ADDR_WIDTH == DEPTH
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   logic                  last_grant;
   logic                  grant0;
   logic                  grant1;
   logic                  xfer;
   logic                  sel_src;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  in_range;
   logic [DEPTH-1:0]      onehot;

   // Grant decision: frozen bank or reset blocks everything; contention favours the requester not served last
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (clr && !hold) begin
         if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign xfer     = grant0 | grant1;
   assign sel_src  = grant1;
   assign sel_addr = grant1 ? req1_addr : req0_addr;
   assign sel_data = grant1 ? req1_data : req0_data;
   assign in_range = {1'b0, sel_addr} < DEPTH_EXT;

   // Decode the granted address into a per-register enable; out-of-range decodes to all-zero
   always_comb begin
      onehot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         onehot[i] = in_range && (sel_addr == ADDR_WIDTH'(i));
      end
   end

   // Remember who was served last so contention alternates
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         last_grant <= 1'b1;
      end else if (xfer) begin
         last_grant <= sel_src;
      end
   end

   // Output stage: enable/error pulse for one cycle per transfer, data/source hold between transfers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wr_en    <= '0;
         wr_data  <= '0;
         wr_src   <= 1'b0;
         err_addr <= 1'b0;
      end else begin
         wr_en    <= xfer ? onehot : '0;
         err_addr <= xfer && !in_range;
         if (xfer) begin
            wr_data <= sel_data;
            wr_src  <= sel_src;
         end
      end
   end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - table-driven scoreboard bench for reg_bank_arbiter
module tb_reg_bank_arbiter;

   logic        clk = 1'b0;
   logic        clr;
   logic        hold;
   logic        req0_valid;
   logic [2:0]  req0_addr;
   logic [31:0] req0_data;
   logic        req1_valid;
   logic [2:0]  req1_addr;
   logic [31:0] req1_data;

   logic        r0_8, r1_8, src8, err8;
   logic [7:0]  en8;
   logic [31:0] data8;
   logic        r0_6, r1_6, src6, err6;
   logic [5:0]  en6;
   logic [31:0] data6;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_bank_arbiter #(.DATA_WIDTH(32), .DEPTH(8), .ADDR_WIDTH(3)) u8 (
      .clk(clk), .clr(clr), .hold(hold),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(r0_8),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(r1_8),
      .wr_en(en8), .wr_data(data8), .wr_src(src8), .err_addr(err8)
   );

   reg_bank_arbiter #(.DATA_WIDTH(32), .DEPTH(6), .ADDR_WIDTH(3)) u6 (
      .clk(clk), .clr(clr), .hold(hold),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(r0_6),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(r1_6),
      .wr_en(en6), .wr_data(data6), .wr_src(src6), .err_addr(err6)
   );

   typedef struct {
      logic        hold;
      logic        v0;
      logic [2:0]  a0;
      logic [31:0] d0;
      logic        v1;
      logic [2:0]  a1;
      logic [31:0] d1;
      logic        r0;
      logic        r1;
   } vec_t;

   typedef struct packed {
      logic [7:0]  en8;
      logic [5:0]  en6;
      logic [31:0] data;
      logic        src;
      logic        err8;
      logic        err6;
   } exp_t;

   vec_t        vecs[$];
   exp_t        q[$];
   logic [31:0] m_data;
   logic        m_src;

   function automatic vec_t mk(input logic h, input logic v0, input logic [2:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [2:0] a1, input logic [31:0] d1,
                               input logic r0, input logic r1);
      vec_t v;
      v.hold = h; v.v0 = v0; v.a0 = a0; v.d0 = d0;
      v.v1 = v1; v.a1 = a1; v.d1 = d1; v.r0 = r0; v.r1 = r1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic sb_reset();
      exp_t e;
      q.delete();
      m_data = '0;
      m_src  = 1'b0;
      e = '0;
      q.push_back(e);
   endtask

   task automatic apply(input vec_t v, input int idx);
      exp_t        e;
      exp_t        n;
      logic [2:0]  a;
      logic [7:0]  oh;
      hold       = v.hold;
      req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
      req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
      @(negedge clk);
      chk($sformatf("v%0d ready0", idx), {31'd0, r0_8}, {31'd0, v.r0});
      chk($sformatf("v%0d ready1", idx), {31'd0, r1_8}, {31'd0, v.r1});
      chk($sformatf("v%0d ready_d6", idx), {30'd0, r0_6, r1_6}, {30'd0, v.r0, v.r1});
      if (q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL v%0d scoreboard empty", idx);
      end else begin
         e = q.pop_front();
         chk($sformatf("v%0d wr_en8", idx), {24'd0, en8}, {24'd0, e.en8});
         chk($sformatf("v%0d wr_en6", idx), {26'd0, en6}, {26'd0, e.en6});
         chk($sformatf("v%0d wr_data", idx), data8, e.data);
         chk($sformatf("v%0d wr_data6", idx), data6, e.data);
         chk($sformatf("v%0d wr_src", idx), {31'd0, src8}, {31'd0, e.src});
         chk($sformatf("v%0d err8", idx), {31'd0, err8}, {31'd0, e.err8});
         chk($sformatf("v%0d err6", idx), {31'd0, err6}, {31'd0, e.err6});
      end
      n      = '0;
      n.data = m_data;
      n.src  = m_src;
      if (v.r0 || v.r1) begin
         a      = v.r1 ? v.a1 : v.a0;
         oh     = 8'd1 << a;
         n.en8  = oh;
         n.en6  = (a < 3'd6) ? oh[5:0] : 6'd0;
         n.err6 = (a >= 3'd6);
         n.data = v.r1 ? v.d1 : v.d0;
         n.src  = v.r1;
         m_data = n.data;
         m_src  = n.src;
      end
      q.push_back(n);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with a pending request: nothing may be granted
      clr = 1'b0; hold = 1'b0;
      req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 32'hDEAD_0000;
      req1_valid = 1'b0; req1_addr = 3'd0; req1_data = 32'h0;
      @(negedge clk);
      chk("rst ready0", {31'd0, r0_8}, 32'd0);
      chk("rst wr_en", {24'd0, en8}, 32'd0);
      chk("rst wr_data", data8, 32'd0);
      chk("rst wr_src", {31'd0, src8}, 32'd0);
      req0_valid = 1'b0;
      clr = 1'b1;
      @(posedge clk);
      #1;
      sb_reset();

      vecs.push_back(mk(1'b0, 1'b1, 3'd3, 32'hA5A5_0001, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd6, 32'h1111_0006, 1'b0, 1'b1));
      for (int i = 0; i < 6; i++) begin
         vecs.push_back(mk(1'b0, 1'b1, 3'd1, 32'hC000_0000 + 32'((i + 1) / 2),
                           1'b1, 3'd2, 32'hD000_0000 + 32'(i / 2),
                           (i % 2) == 0, (i % 2) == 1));
      end
      for (int a = 0; a < 8; a++) begin
         vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'(a), 32'hE000_0000 + 32'(a), 1'b0, 1'b1));
      end
      vecs.push_back(mk(1'b0, 1'b1, 3'd1, 32'hF000_0000, 1'b1, 3'd2, 32'hF000_0001, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'hF000_0001, 1'b0, 1'b1));
      for (int i = 0; i < 4; i++) begin
         vecs.push_back(mk(1'b1, 1'b1, 3'd4, 32'hF000_0003, 1'b1, 3'd5, 32'hF000_0004, 1'b0, 1'b0));
      end
      vecs.push_back(mk(1'b0, 1'b1, 3'd4, 32'hF000_0003, 1'b1, 3'd5, 32'hF000_0004, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd5, 32'hF000_0004, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, 3'd7, 32'h0BAD_0007, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 3'd5, 32'h0000_0505, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 3'd4, 32'hAAAA_0004, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd4, 32'hBBBB_0004, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 3'd2, 32'h2222_0002, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0));

      foreach (vecs[i]) apply(vecs[i], i);

      // Reset during the pulse cycle of the last accepted write
      chk("midop pulse", {24'd0, en8}, 32'h04);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #2;
      clr = 1'b0;
      #1;
      chk("midop wr_en", {24'd0, en8}, 32'd0);
      chk("midop wr_data", data8, 32'd0);
      chk("midop ready", {30'd0, r0_8, r1_8}, 32'd0);
      chk("midop err6", {31'd0, err6}, 32'd0);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      clr = 1'b1;
      sb_reset();
      @(posedge clk);
      #1;
      apply(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0), 100);
      apply(mk(1'b0, 1'b1, 3'd1, 32'h3333_0001, 1'b1, 3'd2, 32'h4444_0002, 1'b1, 1'b0), 101);
      apply(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'h4444_0002, 1'b0, 1'b1), 102);
      apply(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0), 103);
      apply(mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0), 104);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
